// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes num1 - num2 (mod 2^N) one bit per
// clock, LSB first, with one full-subtractor cell and a borrow flop.
// Handshake: start is accepted in IDLE or DONE; busy marks RUN; done pulses
// for one cycle when diff/borrow/zero have just been updated.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  // Bit counter needs clog2(N) bits, but never fewer than one.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  r_next;
  logic [CW-1:0] cnt;
  logic          bin;
  logic          a;
  logic          b;
  logic          d;
  logic          bout;

  // Full-subtractor cell on the current LSBs, and the result register
  // as it will look once this bit's difference is shifted in at the MSB.
  always_comb begin
    // NOTE: every signal gets an unconditional value here, so no latch can be
    // inferred; the MSB overwrite below is a refinement of a full default.
    a           = a_reg[0];
    b           = b_reg[0];
    d           = a ^ b ^ bin;
    bout        = (~a & b) | (~(a ^ b) & bin);
    r_next      = r_reg >> 1;
    r_next[N-1] = d;
  end

  // Control FSM and serial datapath; result outputs load only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge register values regardless of statement order.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= num1;
            b_reg <= num2;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          r_reg <= r_next;
          bin   <= bout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff   <= r_next;
            borrow <= bout;
            zero   <= (r_next == '0);
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags are pure decodes of the state register, so they are glitch-free
  // and clear immediately with the asynchronous reset.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4): directed scenarios plus
// random operands, checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] num1 = '0;
  logic [N-1:0] num2 = '0;
  logic [N-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model state: the last result the DUT should be holding.
  logic [N-1:0] exp_diff   = '0;
  logic         exp_borrow = 1'b0;
  logic         exp_zero   = 1'b0;

  serial_subtractor #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .num1   (num1),
    .num2   (num2),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sampling and driving happen 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain modular arithmetic on integers.
  task automatic model(input int x, input int y);
    int m;
    m          = 1 << N;
    exp_diff   = N'((x - y + m) % m);
    exp_borrow = (x < y);
    exp_zero   = (((x - y + m) % m) == 0);
  endtask

  task automatic check_result(input string tag);
    check({tag, ".done"},   done,   1'b1);
    check({tag, ".busy"},   busy,   1'b0);
    check({tag, ".diff"},   diff,   exp_diff);
    check({tag, ".borrow"}, borrow, exp_borrow);
    check({tag, ".zero"},   zero,   exp_zero);
  endtask

  // One full operation with a single-cycle start pulse; checks busy timing,
  // output hold during RUN, the result, and the return to IDLE.
  task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1;
    num1  = x;
    num2  = y;
    step();                       // E0: accepted
    start = 1'b0;
    num1  = ~x;                   // bus garbage must not matter
    num2  = ~y;
    for (int i = 1; i < N; i++) begin
      check({tag, ".busy_run"}, busy, 1'b1);
      check({tag, ".hold"},     diff, exp_diff);
      step();
    end
    check({tag, ".busy_last"}, busy, 1'b1);
    step();                       // EN: result lands
    model(x, y);
    check_result(tag);
    step();
    check({tag, ".done_end"}, done, 1'b0);
    check({tag, ".busy_end"}, busy, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rx;
    logic [N-1:0] ry;

    // Reset asserted between edges must clear outputs at once.
    #3;
    rst = 1'b1;
    #1;
    check("rst.diff",   diff,   '0);
    check("rst.borrow", borrow, 1'b0);
    check("rst.zero",   zero,   1'b0);
    check("rst.busy",   busy,   1'b0);
    check("rst.done",   done,   1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle.busy", busy, 1'b0);
      check("idle.done", done, 1'b0);
    end

    // Directed arithmetic cases, including underflow, zero and wrap-around.
    run_op("9-3",  4'd9,  4'd3);
    run_op("3-9",  4'd3,  4'd9);
    run_op("5-5",  4'd5,  4'd5);
    run_op("0-15", 4'd0,  4'd15);
    run_op("15-0", 4'd15, 4'd0);

    // start during RUN is ignored and its operands are not sampled.
    start = 1'b1; num1 = 4'd12; num2 = 4'd4;
    step();                       // E0
    start = 1'b0;
    step();                       // E1
    start = 1'b1; num1 = 4'd1; num2 = 4'd1;
    step();                       // E2 (ignored)
    check("ign.busy2", busy, 1'b1);
    step();                       // E3 (ignored)
    start = 1'b0;
    check("ign.busy3", busy, 1'b1);
    step();                       // E4
    model(12, 4);
    check_result("ign");
    step();
    check("ign.no_second_done", done, 1'b0);
    check("ign.no_second_busy", busy, 1'b0);
    step();
    check("ign.still_idle", busy, 1'b0);

    // Back-to-back: start held high, second operands presented during DONE.
    start = 1'b1; num1 = 4'd7; num2 = 4'd2;
    step();                       // E0
    for (int i = 1; i < N; i++) step();
    step();                       // E4: DONE
    model(7, 2);
    check_result("b2b1");
    num1 = 4'd2; num2 = 4'd7;
    step();                       // E5: accepted from DONE
    check("b2b.no_gap_busy", busy, 1'b1);
    check("b2b.no_gap_done", done, 1'b0);
    check("b2b.hold_diff",   diff, exp_diff);
    for (int i = 1; i < N; i++) step();
    step();                       // E9: N+1 cycles after first done
    model(2, 7);
    check_result("b2b2");
    start = 1'b0;
    step();
    check("b2b.end_busy", busy, 1'b0);
    check("b2b.end_done", done, 1'b0);

    // Reset in the middle of a run discards it.
    start = 1'b1; num1 = 4'd15; num2 = 4'd1;
    step();                       // E0
    start = 1'b0;
    step();                       // E1
    step();                       // E2
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst.busy", busy, 1'b0);
    check("mid_rst.done", done, 1'b0);
    check("mid_rst.diff", diff, '0);
    exp_diff = '0; exp_borrow = 1'b0; exp_zero = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      step();
      check("mid_rst.no_done", done, 1'b0);
    end
    run_op("6-6", 4'd6, 4'd6);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rx = N'($urandom_range(0, (1 << N) - 1));
      ry = N'($urandom_range(0, (1 << N) - 1));
      run_op("rand", rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, bit-serial unsigned subtractor: the inverse datapath of the lab's N-bit combinational ripple adder. It computes num1 − num2 one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop. It reports difference, borrow-out and zero flags through a start/busy/done handshake. It sits beside the adder as the SUB path of the lab ALU, where area matters more than latency.

## Interface
- N, default 4: operand and result width in bits; N ≥ 1.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising clk edge
- num1  in  N  minuend (unsigned); sampled with accepted start
- num2  in  N  subtrahend (unsigned); sampled with accepted start
- diff  out  N  registered result num1 − num2 mod 2^N
- borrow  out  1  registered; 1 when num1 < num2 (unsigned)
- zero  out  1  registered; 1 when diff == 0
- busy  out  1  1 while a subtraction is in progress
- done  out  1  one-cycle pulse; result outputs just updated

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch num1/num2 into shift registers A/B.
  - Clear internal borrow flop bin and bit counter cnt.
  - Go to RUN.
- RUN, one bit per edge:
  - a=A[0], b=B[0].
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
  - Shift d into the MSB of internal result register R (R shifts right); shift A and B right; bin ← bout; cnt++.
  - On the edge that processes bit N−1: diff ← final R, borrow ← final bout, zero ← (final R == 0); go to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE: latch operands, go to RUN, no idle cycle needed.
- start while in RUN is ignored; the operands on the bus are not sampled.
- diff/borrow/zero change only on entry to DONE. They hold the previous result through IDLE and RUN.
- busy = (state == RUN). done = (state == DONE).
- Arithmetic is pure modulo 2^N with no saturation. Wrap-around example: 0 − 1 = all ones, borrow=1.
- Counter width is clog2(N) bits, minimum 1. N=1 completes in a single RUN cycle.

## Timing
- Reset values: state=IDLE; diff=0, borrow=0, zero=0, busy=0, done=0. Internal A, B, R, bin and cnt are all 0.
- Reset takes effect immediately and asynchronously, including mid-RUN. The partial result is discarded and outputs go to reset values.
- The first edge after rst deasserts is a normal functional edge.
- Latency: start accepted at edge E0.
  - busy=1 after E0 through edge EN.
  - Bit i is processed at edge E(i+1).
  - After EN: diff/borrow/zero are valid and done=1 for one cycle.
  - After E(N+1): done=0 and busy=0, unless a new start was accepted at EN+1.
- Throughput: one result per N+1 cycles when start is held high continuously.
- start is level-sampled. Holding start high re-triggers in every IDLE or DONE state.

## Test plan
- Reset:
  - Assert rst mid-cycle with no clock edge → all outputs 0 immediately.
  - Release rst, then 3 idle cycles → busy=0, done=0.
- Basic subtraction, N=4:
  - 9 − 3, start pulse at E0 → busy high for 4 edges.
  - done=1 exactly 4 edges after E0.
  - diff=6, borrow=0, zero=0.
- Underflow and zero:
  - 3 − 9 → diff=4'hA, borrow=1, zero=0.
  - 5 − 5 → diff=0, borrow=0, zero=1.
  - 0 − 15 → diff=1, borrow=1.
- Start during RUN:
  - Start 12 − 4; at edge E2 change operands to 1 − 1 with start=1.
  - Required: result diff=8, borrow=0, a single done pulse, no second run started.
- Back-to-back:
  - Hold start high with 7 − 2, then 2 − 7 applied during the DONE cycle.
  - Required: first done with diff=5, borrow=0.
  - Next run starts with no idle gap; second done N+1 cycles later with diff=4'hB, borrow=1.
- Reset mid-run:
  - Start 15 − 1; assert rst after E2.
  - Required: busy=0, done=0, diff=0 immediately, and no done pulse afterwards.
  - A fresh 6 − 6 after reset yields zero=1.
